vector_add_arbiter: RTL
=======================

VECTOR_ADD_ARBITER -- requirements
Module: vector_add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one vector adder.
REQ-002 Parameter LANES, default 4: elements per beat.
REQ-003 Parameter DATA_WIDTH, default 32: bits per element.
REQ-004 Parameter INDEX_WIDTH, default 8: beat index width.
REQ-005 Port clk  in  1: single clock; all logic rising-edge.
REQ-006 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 Ports req_x_valid/req_y_valid  in  N_REQ: per-requester operand beat valid.
REQ-008 Ports req_x_ready/req_y_ready  out  N_REQ: per-requester operand beat accepted.
REQ-009 Ports req_x_data/req_y_data  in  N_REQ x LANES*DATA_WIDTH: operand payload.
REQ-010 Ports req_x_index/req_y_index  in  N_REQ x INDEX_WIDTH; req_x_last/req_y_last  in  N_REQ; req_x_keep/req_y_keep  in  N_REQ x LANES.
REQ-011 Ports add_valid  out  1; add_ready  in  1: issue handshake toward adder.
REQ-012 Ports add_x_data/add_y_data  out  LANES*DATA_WIDTH; add_index  out  INDEX_WIDTH; add_last  out  1; add_keep  out  LANES; add_id  out  clog2(N_REQ).
REQ-013 Ports busy  out  1 (packet locked); grant_id  out  clog2(N_REQ); err_mismatch  out  1 (sticky); clear_err  in  1.

Function
REQ-014 FSM states IDLE, ARB, BUSY; one packet = beats up to and including the accepted beat with x_last=1.
REQ-015 IDLE: a requester is eligible when its x_valid and y_valid are both 1; any eligible -> ARB next cycle.
REQ-016 ARB: round-robin select of first eligible requester at or after rr_ptr (wrap N_REQ-1 -> 0); grant_id registered, -> BUSY; no beat accepted in ARB (one-cycle bubble).
REQ-017 ARB with no eligible requester (valids withdrawn) -> IDLE, grant_id unchanged.
REQ-018 BUSY: beat accepted when granted x_valid and y_valid both 1 and out_free = !add_valid || add_ready; req_x_ready and req_y_ready of the granted requester both asserted exactly then; all other ready bits 0.
REQ-019 Ready SHALL NOT depend on the requester's own valid for non-granted requesters; x and y accepted in the same cycle, never separately.
REQ-020 Accepted beat loads the one-entry output register: add_x_data, add_y_data, add_index = x_index, add_last = x_last, add_keep = x_keep AND y_keep, add_id = grant_id; add_valid=1 next cycle.
REQ-021 Latency: accepted beat appears on add_* exactly one cycle later; full throughput one beat/cycle while add_ready=1.
REQ-022 Output register holds stable while add_valid=1 and add_ready=0; cleared when add_ready=1 with no new load.
REQ-023 Accepting a beat with x_last=1: -> IDLE, rr_ptr = grant_id+1 mod N_REQ; next packet needs ARB again.
REQ-024 Mismatch: accepted beat with x_index != y_index or x_last != y_last sets err_mismatch; beat still forwarded; packet end follows x_last.
REQ-025 err_mismatch clears on clear_err=1 next cycle; simultaneous set and clear -> set wins.
REQ-026 busy = 1 in BUSY or while add_valid=1.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, rr_ptr 0, grant_id 0, add_valid 0, add_* payload 0, all ready 0, err_mismatch 0, busy 0.
REQ-028 Reset mid-packet discards held beat and lock; first post-reset grant follows REQ-016 with rr_ptr 0.

Structure
REQ-029 State enum, default parameter constants and beat struct (data, index, last, keep) SHALL live in shared package vector_pkg.
REQ-030 Round-robin selection SHALL be sub-module rr_arbiter (request vector, pointer in; one-hot grant, index, any out); remaining logic in top.

Verification
REQ-031 Requesters 0 and 2 both eligible after reset, 3-beat packets, add_ready=1 -> req 0 served (add_id=0, 3 beats, indices 0,1,2), then req 2; 1-cycle ARB bubble between.
REQ-032 All 4 continuously eligible, 1-beat packets -> grant order 0,1,2,3,0 (wrap).
REQ-033 add_ready=0 for 5 cycles mid-packet -> add_* stable, granted ready=0, no beat lost or duplicated; resume at 1 beat/cycle.
REQ-034 Granted y_valid low 2 cycles while x_valid=1 -> neither x nor y accepted; no add_valid gap fill.
REQ-035 Beat with x_index=5, y_index=6 -> err_mismatch=1 next cycle, beat forwarded; clear_err pulse -> 0.
REQ-036 rst_n asserted during beat 2 of 4 -> all outputs at reset values immediately; after release, rr_ptr=0 ordering restored.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and default sizing for the vector add arbiter slice.
//   state_t : arbitration FSM states
//   beat_t  : one issued beat (data, index, last, keep) at default sizing
package vector_pkg;

    localparam int unsigned N_REQ_DEF       = 4;
    localparam int unsigned LANES_DEF       = 4;
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned INDEX_WIDTH_DEF = 8;
    localparam int unsigned BEAT_W_DEF      = LANES_DEF * DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } state_t;

    typedef struct packed {
        logic [BEAT_W_DEF-1:0]      data;
        logic [INDEX_WIDTH_DEF-1:0] index;
        logic                       last;
        logic [LANES_DEF-1:0]       keep;
    } beat_t;

endpackage

// File: rtl/vector_add_arbiter_if.sv
// Requester and adder-side bus of the vector add arbiter.
//   req_*  : per-requester x/y operand channels (valid/ready/data/index/last/keep)
//   add_*  : single issue channel toward the adder
//   busy, grant_id, err_mismatch, clear_err : status and error control
//   slave  : arbiter view; master : requester/adder view
interface vector_add_arbiter_if import vector_pkg::*; #(
    parameter int unsigned N_REQ       = N_REQ_DEF,
    parameter int unsigned LANES       = LANES_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF
);
    localparam int unsigned DW   = LANES * DATA_WIDTH;
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]                  req_x_valid, req_y_valid;
    logic [N_REQ-1:0]                  req_x_ready, req_y_ready;
    logic [N_REQ-1:0][DW-1:0]          req_x_data,  req_y_data;
    logic [N_REQ-1:0][INDEX_WIDTH-1:0] req_x_index, req_y_index;
    logic [N_REQ-1:0]                  req_x_last,  req_y_last;
    logic [N_REQ-1:0][LANES-1:0]       req_x_keep,  req_y_keep;

    logic                   add_valid;
    logic                   add_ready;
    logic [DW-1:0]          add_x_data, add_y_data;
    logic [INDEX_WIDTH-1:0] add_index;
    logic                   add_last;
    logic [LANES-1:0]       add_keep;
    logic [ID_W-1:0]        add_id;

    logic            busy;
    logic [ID_W-1:0] grant_id;
    logic            err_mismatch;
    logic            clear_err;

    modport slave (
        input  req_x_valid, req_y_valid, req_x_data, req_y_data,
               req_x_index, req_y_index, req_x_last, req_y_last,
               req_x_keep, req_y_keep, add_ready, clear_err,
        output req_x_ready, req_y_ready, add_valid, add_x_data, add_y_data,
               add_index, add_last, add_keep, add_id, busy, grant_id, err_mismatch
    );

    modport master (
        output req_x_valid, req_y_valid, req_x_data, req_y_data,
               req_x_index, req_y_index, req_x_last, req_y_last,
               req_x_keep, req_y_keep, add_ready, clear_err,
        input  req_x_ready, req_y_ready, add_valid, add_x_data, add_y_data,
               add_index, add_last, add_keep, add_id, busy, grant_id, err_mismatch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set request at or after i_ptr, wrapping.
//   i_req : request vector     i_ptr : search start
//   o_gnt : one-hot grant      o_idx : grant index     o_any : any request
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(i_ptr) + i) % N;
            if (!o_any && i_req[IDX_W'(cand)]) begin
                o_any                 = 1'b1;
                o_idx                 = IDX_W'(cand);
                o_gnt[IDX_W'(cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_add_arbiter.sv
// Shares one vector adder among N_REQ requesters with packet-locked
// round-robin arbitration and a one-entry registered issue stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : requester x/y channels, adder issue channel, status/error
module vector_add_arbiter import vector_pkg::*; #(
    parameter int unsigned N_REQ       = N_REQ_DEF,
    parameter int unsigned LANES       = LANES_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    vector_add_arbiter_if.slave bus
);
    localparam int unsigned DW   = LANES * DATA_WIDTH;
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr, r_grant_id;
    logic [N_REQ-1:0]  r_grant_oh;
    beat_t             r_out;
    logic [DW-1:0]     r_out_y_data;
    logic              r_out_valid;
    logic [ID_W-1:0]   r_out_id;
    logic              r_err;

    logic [N_REQ-1:0]  w_eligible, w_arb_gnt, w_ready;
    logic [ID_W-1:0]   w_arb_idx;
    logic              w_arb_any, w_out_free, w_accept, w_beat_last, w_mismatch;

    assign w_eligible = bus.req_x_valid & bus.req_y_valid;

    rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_rr_arbiter (
        .i_req (w_eligible),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // x and y are taken together only, from the locked requester, when the issue slot frees
    assign w_out_free  = !r_out_valid || bus.add_ready;
    assign w_accept    = (r_state == BUSY) && bus.req_x_valid[r_grant_id]
                         && bus.req_y_valid[r_grant_id] && w_out_free;
    assign w_beat_last = bus.req_x_last[r_grant_id];
    assign w_mismatch  = (bus.req_x_index[r_grant_id] != bus.req_y_index[r_grant_id])
                         || (bus.req_x_last[r_grant_id] != bus.req_y_last[r_grant_id]);

    // Ready is the accept strobe steered to the granted requester
    always_comb begin
        w_ready = '0;
        if (w_accept) w_ready = r_grant_oh;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; packet end follows x_last only
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_eligible) w_state_nxt = ARB;
            ARB:     w_state_nxt = w_arb_any ? BUSY : IDLE;
            BUSY:    if (w_accept && w_beat_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, pointer, issue register and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_grant_oh   <= '0;
            r_out        <= '0;
            r_out_y_data <= '0;
            r_out_valid  <= 1'b0;
            r_out_id     <= '0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == ARB && w_arb_any) begin
                r_grant_id <= w_arb_idx;
                r_grant_oh <= w_arb_gnt;
            end
            if (w_accept && w_beat_last) begin
                r_rr_ptr <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : ID_W'(r_grant_id + 1'b1);
            end
            if (w_accept) begin
                r_out.data   <= bus.req_x_data[r_grant_id];
                r_out.index  <= bus.req_x_index[r_grant_id];
                r_out.last   <= bus.req_x_last[r_grant_id];
                r_out.keep   <= bus.req_x_keep[r_grant_id] & bus.req_y_keep[r_grant_id];
                r_out_y_data <= bus.req_y_data[r_grant_id];
                r_out_id     <= r_grant_id;
                r_out_valid  <= 1'b1;
            end else if (bus.add_ready) begin
                r_out        <= '0;
                r_out_y_data <= '0;
                r_out_id     <= '0;
                r_out_valid  <= 1'b0;
            end
            // Set takes priority over a same-cycle clear
            if (w_accept && w_mismatch) r_err <= 1'b1;
            else if (bus.clear_err)     r_err <= 1'b0;
        end
    end

    assign bus.req_x_ready  = w_ready;
    assign bus.req_y_ready  = w_ready;
    assign bus.add_valid    = r_out_valid;
    assign bus.add_x_data   = r_out.data;
    assign bus.add_y_data   = r_out_y_data;
    assign bus.add_index    = r_out.index;
    assign bus.add_last     = r_out.last;
    assign bus.add_keep     = r_out.keep;
    assign bus.add_id       = r_out_id;
    assign bus.busy         = (r_state == BUSY) || r_out_valid;
    assign bus.grant_id     = r_grant_id;
    assign bus.err_mismatch = r_err;

endmodule
